// File: rtl/sdram_timing_monitor_pkg.sv
// Shared types and default timing for the SDRAM timing monitor.
// Command encodings, violation codes, init sub-states and the command decode helper.
package sdram_timing_monitor_pkg;

    localparam int SDRAM_BANKS_DEF        = 4;
    localparam int SDRAM_ROW_W_DEF        = 13;
    localparam int SDRAM_TRCD_CYCLES_DEF  = 3;
    localparam int SDRAM_TRP_CYCLES_DEF   = 3;
    localparam int SDRAM_TRAS_CYCLES_DEF  = 6;
    localparam int SDRAM_TRFC_CYCLES_DEF  = 9;
    localparam int SDRAM_TREFI_CYCLES_DEF = 780;
    localparam int ERR_CNT_W_DEF          = 16;

    typedef enum logic [3:0] {
        CMD_LOAD_MODE = 4'b0000,
        CMD_REFRESH   = 4'b0001,
        CMD_PRECHARGE = 4'b0010,
        CMD_ACTIVE    = 4'b0011,
        CMD_WRITE     = 4'b0100,
        CMD_READ      = 4'b0101,
        CMD_NOP       = 4'b0111
    } cmd_e;

    typedef enum logic [2:0] {
        ERR_TRCD    = 3'd0,
        ERR_TRP     = 3'd1,
        ERR_CLOSED  = 3'd2,
        ERR_REOPEN  = 3'd3,
        ERR_TRAS    = 3'd4,
        ERR_REFRESH = 3'd5,
        ERR_TREFI   = 3'd6,
        ERR_INIT    = 3'd7
    } mon_err_e;

    typedef enum logic [2:0] {
        INIT_PRE  = 3'd0,
        INIT_REF1 = 3'd1,
        INIT_REF2 = 3'd2,
        INIT_MODE = 3'd3,
        INIT_DONE = 3'd4
    } init_state_e;

    // A deselected chip or a stopped clock enable looks like a NOP to the monitor.
    function automatic cmd_e decode_cmd(input logic cke, input logic cs, input logic ras,
                                        input logic cas, input logic we);
        if (!cke || cs) begin
            return CMD_NOP;
        end
        return cmd_e'({1'b0, ras, cas, we});
    endfunction

endpackage

// File: rtl/sdram_bank_tracker.sv
// Per-bank open flag plus tRCD/tRAS/tRP timers for the SDRAM timing monitor.
// Reports this bank's share of the TRCD, TRP, CLOSED, REOPEN and TRAS checks.
module sdram_bank_tracker
    import sdram_timing_monitor_pkg::*;
#(
    parameter int TRCD_CYCLES = SDRAM_TRCD_CYCLES_DEF,
    parameter int TRP_CYCLES  = SDRAM_TRP_CYCLES_DEF,
    parameter int TRAS_CYCLES = SDRAM_TRAS_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic act_i,
    input  logic rdwr_i,
    input  logic pre_i,
    output logic open_o,
    output logic err_trcd_o,
    output logic err_trp_o,
    output logic err_closed_o,
    output logic err_reopen_o,
    output logic err_tras_o
);

    localparam int TRCD_W = (TRCD_CYCLES > 1) ? $clog2(TRCD_CYCLES) : 1;
    localparam int TRP_W  = (TRP_CYCLES  > 1) ? $clog2(TRP_CYCLES)  : 1;
    localparam int TRAS_W = (TRAS_CYCLES > 1) ? $clog2(TRAS_CYCLES) : 1;

    logic              open_q, open_d;
    logic [TRCD_W-1:0] trcd_q, trcd_d;
    logic [TRP_W-1:0]  trp_q,  trp_d;
    logic [TRAS_W-1:0] tras_q, tras_d;

    // Timers load X-1 on their command and count down to 0; state tracks even illegal commands.
    always_comb begin
        open_d = open_q;
        trcd_d = (trcd_q != '0) ? trcd_q - TRCD_W'(1) : trcd_q;
        trp_d  = (trp_q  != '0) ? trp_q  - TRP_W'(1)  : trp_q;
        tras_d = (tras_q != '0) ? tras_q - TRAS_W'(1) : tras_q;
        if (act_i) begin
            open_d = 1'b1;
            trcd_d = TRCD_W'(TRCD_CYCLES - 1);
            tras_d = TRAS_W'(TRAS_CYCLES - 1);
        end
        if (pre_i) begin
            open_d = 1'b0;
            trp_d  = TRP_W'(TRP_CYCLES - 1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            open_q <= 1'b0;
            trcd_q <= '0;
            trp_q  <= '0;
            tras_q <= '0;
        end else begin
            open_q <= open_d;
            trcd_q <= trcd_d;
            trp_q  <= trp_d;
            tras_q <= tras_d;
        end
    end

    assign open_o       = open_q;
    assign err_trcd_o   = rdwr_i && (trcd_q != '0);
    assign err_closed_o = rdwr_i && !open_q;
    assign err_trp_o    = act_i && (trp_q != '0);
    assign err_reopen_o = act_i && open_q;
    assign err_tras_o   = pre_i && open_q && (tras_q != '0);

endmodule

// File: rtl/sdram_timing_monitor.sv
// Passive SDRAM command/timing monitor: bank state, timers, init order and violation reporting.
// Optional SDRAM_MON_STATS_EN adds ACTIVE and READ/WRITE statistics counters.
module sdram_timing_monitor
    import sdram_timing_monitor_pkg::*;
#(
    parameter int SDRAM_BANKS        = SDRAM_BANKS_DEF,
    parameter int SDRAM_ROW_W        = SDRAM_ROW_W_DEF,
    parameter int SDRAM_TRCD_CYCLES  = SDRAM_TRCD_CYCLES_DEF,
    parameter int SDRAM_TRP_CYCLES   = SDRAM_TRP_CYCLES_DEF,
    parameter int SDRAM_TRAS_CYCLES  = SDRAM_TRAS_CYCLES_DEF,
    parameter int SDRAM_TRFC_CYCLES  = SDRAM_TRFC_CYCLES_DEF,
    parameter int SDRAM_TREFI_CYCLES = SDRAM_TREFI_CYCLES_DEF,
    parameter int ERR_CNT_W          = ERR_CNT_W_DEF
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           sdram_cke_i,
    input  logic                           sdram_cs_i,
    input  logic                           sdram_ras_i,
    input  logic                           sdram_cas_i,
    input  logic                           sdram_we_i,
    input  logic [$clog2(SDRAM_BANKS)-1:0] sdram_ba_i,
    input  logic [SDRAM_ROW_W-1:0]         sdram_addr_i,
    input  logic                           err_clear_i,
    output logic                           init_done_o,
    output logic [SDRAM_BANKS-1:0]         banks_open_o,
    output logic                           err_valid_o,
    output logic [2:0]                     err_code_o,
    output logic [$clog2(SDRAM_BANKS)-1:0] err_bank_o,
    output logic [7:0]                     err_sticky_o,
    output logic [ERR_CNT_W-1:0]           err_count_o,
    output logic [31:0]                    stat_act_o,
    output logic [31:0]                    stat_rdwr_o
);

    localparam int BA_W   = $clog2(SDRAM_BANKS);
    localparam int A10    = 10;
    localparam int TRFC_W = (SDRAM_TRFC_CYCLES > 1) ? $clog2(SDRAM_TRFC_CYCLES) : 1;
    localparam int REFI_W = $clog2(SDRAM_TREFI_CYCLES + 1);

    cmd_e        cmd;
    logic        is_act, is_rdwr, is_pre, is_ref, is_mode, is_nop;
    init_state_e init_q;
    logic        init_done_q;

    logic [SDRAM_BANKS-1:0] bank_open, bank_trcd, bank_trp, bank_closed, bank_reopen, bank_tras;

    logic [TRFC_W-1:0]    trfc_q, trfc_d;
    logic [REFI_W-1:0]    refi_q, refi_d;
    logic [7:0]           err_vec;
    logic [2:0]           first_code;
    logic [BA_W-1:0]      tras_bank, first_bank;
    logic                 err_valid_q, err_valid_d;
    logic [2:0]           err_code_q, err_code_d;
    logic [BA_W-1:0]      err_bank_q, err_bank_d;
    logic [7:0]           sticky_q, sticky_d;
    logic [ERR_CNT_W-1:0] count_q, count_d;

    always_comb begin
        cmd     = decode_cmd(sdram_cke_i, sdram_cs_i, sdram_ras_i, sdram_cas_i, sdram_we_i);
        is_act  = (cmd == CMD_ACTIVE);
        is_rdwr = (cmd == CMD_READ) || (cmd == CMD_WRITE);
        is_pre  = (cmd == CMD_PRECHARGE);
        is_ref  = (cmd == CMD_REFRESH);
        is_mode = (cmd == CMD_LOAD_MODE);
        is_nop  = (cmd == CMD_NOP);
    end

    for (genvar b = 0; b < SDRAM_BANKS; b++) begin : g_bank
        logic sel;
        assign sel = (sdram_ba_i == BA_W'(b));

        sdram_bank_tracker #(
            .TRCD_CYCLES (SDRAM_TRCD_CYCLES),
            .TRP_CYCLES  (SDRAM_TRP_CYCLES),
            .TRAS_CYCLES (SDRAM_TRAS_CYCLES)
        ) u_bank (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .act_i        (is_act && sel),
            .rdwr_i       (is_rdwr && sel),
            .pre_i        (is_pre && (sel || sdram_addr_i[A10])),
            .open_o       (bank_open[b]),
            .err_trcd_o   (bank_trcd[b]),
            .err_trp_o    (bank_trp[b]),
            .err_closed_o (bank_closed[b]),
            .err_reopen_o (bank_reopen[b]),
            .err_tras_o   (bank_tras[b])
        );
    end

    // Init order: PRECHARGE-all, two REFRESHes, LOAD_MODE; anything else is ignored while waiting.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            init_q      <= INIT_PRE;
            init_done_q <= 1'b0;
        end else begin
            case (init_q)
                INIT_PRE:  if (is_pre && sdram_addr_i[A10]) init_q <= INIT_REF1;
                INIT_REF1: if (is_ref) init_q <= INIT_REF2;
                INIT_REF2: if (is_ref) init_q <= INIT_MODE;
                INIT_MODE: begin
                    if (is_mode) begin
                        init_q      <= INIT_DONE;
                        init_done_q <= 1'b1;
                    end
                end
                default: init_q <= init_q;
            endcase
        end
    end

    // tRFC runs from every REFRESH; tREFI only counts once init is done and saturates at its limit.
    always_comb begin
        trfc_d = (trfc_q != '0) ? trfc_q - TRFC_W'(1) : trfc_q;
        if (is_ref) begin
            trfc_d = TRFC_W'(SDRAM_TRFC_CYCLES - 1);
        end
        refi_d = refi_q;
        if (init_q != INIT_DONE || is_ref) begin
            refi_d = '0;
        end else if (refi_q != REFI_W'(SDRAM_TREFI_CYCLES)) begin
            refi_d = refi_q + REFI_W'(1);
        end
    end

    always_comb begin
        err_vec = '0;
        if (init_q == INIT_DONE) begin
            err_vec[ERR_TRCD]    = |bank_trcd;
            err_vec[ERR_TRP]     = |bank_trp;
            err_vec[ERR_CLOSED]  = |bank_closed;
            err_vec[ERR_REOPEN]  = |bank_reopen;
            err_vec[ERR_TRAS]    = |bank_tras;
            err_vec[ERR_REFRESH] = (is_ref && (|bank_open)) || (!is_nop && (trfc_q != '0));
            err_vec[ERR_TREFI]   = !is_ref && (refi_q == REFI_W'(SDRAM_TREFI_CYCLES - 1));
        end else begin
            err_vec[ERR_INIT]    = is_act || is_rdwr;
        end

        first_code = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (err_vec[i]) first_code = 3'(i);
        end

        tras_bank = '0;
        for (int b = SDRAM_BANKS - 1; b >= 0; b--) begin
            if (bank_tras[b]) tras_bank = BA_W'(b);
        end

        if (first_code == ERR_TRAS) begin
            first_bank = tras_bank;
        end else if (first_code == ERR_TREFI) begin
            first_bank = '0;
        end else begin
            first_bank = sdram_ba_i;
        end
    end

    // A same-cycle clear wins: the violation in that cycle is dropped entirely.
    always_comb begin
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        err_bank_d  = err_bank_q;
        sticky_d    = sticky_q;
        count_d     = count_q;
        if (err_clear_i) begin
            sticky_d = '0;
            count_d  = '0;
        end else if (|err_vec) begin
            err_valid_d = 1'b1;
            err_code_d  = first_code;
            err_bank_d  = first_bank;
            sticky_d    = sticky_q | err_vec;
            if (count_q != '1) begin
                count_d = count_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            trfc_q      <= '0;
            refi_q      <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            err_bank_q  <= '0;
            sticky_q    <= '0;
            count_q     <= '0;
        end else begin
            trfc_q      <= trfc_d;
            refi_q      <= refi_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_bank_q  <= err_bank_d;
            sticky_q    <= sticky_d;
            count_q     <= count_d;
        end
    end

`ifdef SDRAM_MON_STATS_EN
    logic [31:0] stat_act_q, stat_act_d, stat_rdwr_q, stat_rdwr_d;

    always_comb begin
        stat_act_d  = stat_act_q;
        stat_rdwr_d = stat_rdwr_q;
        if (err_clear_i) begin
            stat_act_d  = '0;
            stat_rdwr_d = '0;
        end else begin
            if (is_act)  stat_act_d  = stat_act_q + 32'd1;
            if (is_rdwr) stat_rdwr_d = stat_rdwr_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stat_act_q  <= '0;
            stat_rdwr_q <= '0;
        end else begin
            stat_act_q  <= stat_act_d;
            stat_rdwr_q <= stat_rdwr_d;
        end
    end

    assign stat_act_o  = stat_act_q;
    assign stat_rdwr_o = stat_rdwr_q;
`else
    assign stat_act_o  = '0;
    assign stat_rdwr_o = '0;
`endif

    assign init_done_o  = init_done_q;
    assign banks_open_o = bank_open;
    assign err_valid_o  = err_valid_q;
    assign err_code_o   = err_code_q;
    assign err_bank_o   = err_bank_q;
    assign err_sticky_o = sticky_q;
    assign err_count_o  = count_q;

endmodule

// File: tb/tb_sdram_timing_monitor.sv
// Directed bench for sdram_timing_monitor: each command cycle pushes its expected report
// onto a scoreboard queue that is popped and checked once the registered outputs settle.
module tb_sdram_timing_monitor;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        sdram_cke = 1'b1;
    logic        sdram_cs  = 1'b0;
    logic        sdram_ras = 1'b1;
    logic        sdram_cas = 1'b1;
    logic        sdram_we  = 1'b1;
    logic [1:0]  sdram_ba  = 2'd0;
    logic [12:0] sdram_addr = 13'd0;
    logic        err_clear = 1'b0;

    logic        init_done_o;
    logic [3:0]  banks_open_o;
    logic        err_valid_o;
    logic [2:0]  err_code_o;
    logic [1:0]  err_bank_o;
    logic [7:0]  err_sticky_o;
    logic [15:0] err_count_o;
    logic [31:0] stat_act_o;
    logic [31:0] stat_rdwr_o;

    typedef struct {
        logic        valid;
        logic [2:0]  code;
        logic [1:0]  bank;
        logic [7:0]  sticky;
        logic [15:0] count;
        logic [31:0] act;
        logic [31:0] rdwr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  m_sticky = 8'h00;
    logic [15:0] m_count  = 16'h0000;
    logic [31:0] m_act    = 32'd0;
    logic [31:0] m_rdwr   = 32'd0;

    sdram_timing_monitor dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sdram_cke_i  (sdram_cke),
        .sdram_cs_i   (sdram_cs),
        .sdram_ras_i  (sdram_ras),
        .sdram_cas_i  (sdram_cas),
        .sdram_we_i   (sdram_we),
        .sdram_ba_i   (sdram_ba),
        .sdram_addr_i (sdram_addr),
        .err_clear_i  (err_clear),
        .init_done_o  (init_done_o),
        .banks_open_o (banks_open_o),
        .err_valid_o  (err_valid_o),
        .err_code_o   (err_code_o),
        .err_bank_o   (err_bank_o),
        .err_sticky_o (err_sticky_o),
        .err_count_o  (err_count_o),
        .stat_act_o   (stat_act_o),
        .stat_rdwr_o  (stat_rdwr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One command cycle: drive at negedge, push the expected report, check #1 after the posedge.
    task automatic applyStimulus(input logic [3:0] cmd, input logic [1:0] ba, input logic a10,
                                 input logic clr, input logic [7:0] mask, input logic [1:0] ebank,
                                 input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk_i);
        {sdram_cs, sdram_ras, sdram_cas, sdram_we} = cmd;
        sdram_ba   = ba;
        sdram_addr = {2'b00, a10, 10'h000};
        err_clear  = clr;
        if (clr) begin
            m_sticky = 8'h00;
            m_count  = 16'h0000;
            m_act    = 32'd0;
            m_rdwr   = 32'd0;
        end else begin
            if (mask != 8'h00) begin
                m_sticky = m_sticky | mask;
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            end
            if (cmd == C_ACT) m_act = m_act + 32'd1;
            if (cmd == C_RD || cmd == C_WR) m_rdwr = m_rdwr + 32'd1;
        end
        e.valid = (mask != 8'h00) && !clr;
        e.code  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) e.code = 3'(i);
        end
        e.bank   = ebank;
        e.sticky = m_sticky;
        e.count  = m_count;
`ifdef SDRAM_MON_STATS_EN
        e.act  = m_act;
        e.rdwr = m_rdwr;
`else
        e.act  = 32'd0;
        e.rdwr = 32'd0;
`endif
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        checkOutput({tag, ".sb_depth"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            checkOutput({tag, ".valid"}, 32'(err_valid_o), 32'(got.valid));
            if (got.valid) begin
                checkOutput({tag, ".code"}, 32'(err_code_o), 32'(got.code));
                checkOutput({tag, ".bank"}, 32'(err_bank_o), 32'(got.bank));
            end
            checkOutput({tag, ".sticky"}, 32'(err_sticky_o), 32'(got.sticky));
            checkOutput({tag, ".count"}, 32'(err_count_o), 32'(got.count));
            checkOutput({tag, ".stat_act"}, stat_act_o, got.act);
            checkOutput({tag, ".stat_rdwr"}, stat_rdwr_o, got.rdwr);
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(C_NOP, 2'd0, 1'b0, 1'b0, 8'h00, 2'd0, tag);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".init_done"}, 32'(init_done_o), 32'd0);
        checkOutput({tag, ".banks_open"}, 32'(banks_open_o), 32'd0);
        checkOutput({tag, ".valid"}, 32'(err_valid_o), 32'd0);
        checkOutput({tag, ".code"}, 32'(err_code_o), 32'd0);
        checkOutput({tag, ".bank"}, 32'(err_bank_o), 32'd0);
        checkOutput({tag, ".sticky"}, 32'(err_sticky_o), 32'd0);
        checkOutput({tag, ".count"}, 32'(err_count_o), 32'd0);
        checkOutput({tag, ".stat_act"}, stat_act_o, 32'd0);
        checkOutput({tag, ".stat_rdwr"}, stat_rdwr_o, 32'd0);
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) @(posedge clk_i);
        #1;
        checkResetState("reset");
        @(negedge clk_i);
        rst_i = 1'b1;

        // Init sequence with an early ACTIVE, which only the INIT check may flag.
        applyStimulus(C_ACT, 2'd0, 1'b0, 1'b0, 8'h80, 2'd0, "init_early_act");
        checkOutput("init_early_act.open", 32'(banks_open_o), 32'h1);
        applyStimulus(C_PRE, 2'd0, 1'b1, 1'b0, 8'h00, 2'd0, "init_pre_all");
        checkOutput("init_pre_all.open", 32'(banks_open_o), 32'h0);
        idle(2, "init_gap0");
        applyStimulus(C_REF, 2'd0, 1'b0, 1'b0, 8'h00, 2'd0, "init_ref1");
        idle(9, "init_gap1");
        applyStimulus(C_REF, 2'd0, 1'b0, 1'b0, 8'h00, 2'd0, "init_ref2");
        idle(9, "init_gap2");
        checkOutput("init_before_mode.done", 32'(init_done_o), 32'd0);
        applyStimulus(C_MRS, 2'd0, 1'b0, 1'b0, 8'h00, 2'd0, "init_mode");
        checkOutput("init_after_mode.done", 32'(init_done_o), 32'd1);

        // tRCD: READ two cycles after ACTIVE violates, three cycles after is legal.
        applyStimulus(C_ACT, 2'd2, 1'b0, 1'b0, 8'h00, 2'd0, "trcd_act");
        checkOutput("trcd_act.open", 32'(banks_open_o), 32'h4);
        idle(1, "trcd_gap");
        applyStimulus(C_RD, 2'd2, 1'b0, 1'b0, 8'h01, 2'd2, "trcd_early_read");
        idle(3, "tras_wait");
        applyStimulus(C_PRE, 2'd2, 1'b0, 1'b0, 8'h00, 2'd0, "tras_exact_pre");
        idle(2, "trp_wait");
        applyStimulus(C_ACT, 2'd2, 1'b0, 1'b0, 8'h00, 2'd0, "trp_exact_act");
        idle(2, "trcd_wait");
        applyStimulus(C_RD, 2'd2, 1'b0, 1'b0, 8'h00, 2'd0, "trcd_exact_read");
        applyStimulus(C_WR, 2'd2, 1'b0, 1'b0, 8'h00, 2'd0, "rdwr_1");
        applyStimulus(C_RD, 2'd2, 1'b0, 1'b0, 8'h00, 2'd0, "rdwr_2");
        applyStimulus(C_WR, 2'd2, 1'b0, 1'b0, 8'h00, 2'd0, "rdwr_3");
        applyStimulus(C_RD, 2'd2, 1'b0, 1'b0, 8'h00, 2'd0, "rdwr_4");
        applyStimulus(C_PRE, 2'd2, 1'b0, 1'b0, 8'h00, 2'd0, "close_bank2");
        checkOutput("close_bank2.open", 32'(banks_open_o), 32'h0);

        applyStimulus(C_NOP, 2'd0, 1'b0, 1'b1, 8'h00, 2'd0, "clear_idle");

        // tRAS then tRP on bank 1.
        applyStimulus(C_ACT, 2'd1, 1'b0, 1'b0, 8'h00, 2'd0, "tras_act");
        idle(3, "tras_gap");
        applyStimulus(C_PRE, 2'd1, 1'b0, 1'b0, 8'h10, 2'd1, "tras_early_pre");
        applyStimulus(C_ACT, 2'd1, 1'b0, 1'b0, 8'h02, 2'd1, "trp_early_act");
        checkOutput("tras_trp.count", 32'(err_count_o), 32'd2);
        idle(5, "bank1_wait");
        applyStimulus(C_PRE, 2'd1, 1'b0, 1'b0, 8'h00, 2'd0, "close_bank1");

        // READ to a closed bank while tRFC runs: CLOSED and REFRESH together.
        applyStimulus(C_REF, 2'd0, 1'b0, 1'b0, 8'h00, 2'd0, "refresh_c");
        idle(1, "trfc_gap");
        applyStimulus(C_RD, 2'd3, 1'b0, 1'b0, 8'h24, 2'd3, "closed_in_trfc");
        idle(9, "trfc_wait");

        // tREFI: 780 cycles after the REFRESH above, exactly one pulse, then saturated.
        idle(768, "trefi_quiet");
        applyStimulus(C_NOP, 2'd0, 1'b0, 1'b0, 8'h40, 2'd0, "trefi_expire");
        idle(30, "trefi_hold");
        applyStimulus(C_REF, 2'd0, 1'b0, 1'b0, 8'h00, 2'd0, "trefi_restart");

        // Clear in the same cycle as a violation: the clear wins.
        applyStimulus(C_RD, 2'd3, 1'b0, 1'b1, 8'h24, 2'd3, "clear_vs_error");
        idle(9, "post_clear");
        applyStimulus(C_ACT, 2'd3, 1'b0, 1'b0, 8'h00, 2'd0, "reopen_first");
        applyStimulus(C_ACT, 2'd3, 1'b0, 1'b0, 8'h08, 2'd3, "reopen_second");
        checkOutput("reopen.open", 32'(banks_open_o), 32'h8);

        // Asynchronous reset mid-operation, sampled before the next clock edge.
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        checkResetState("async_reset");
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_timing_monitor.md
Name: sdram_timing_monitor

Overview:
- Synthesizable, parametrised SDRAM command/timing monitor for N banks.
- Passively observes the controller-to-SDRAM command pins and tracks per-bank open/closed state, per-bank tRCD/tRAS/tRP timers, tRFC and tREFI, plus init-sequence order.
- Flags protocol and timing violations through pulse, sticky and counter outputs.
- Sits beside sdram_ctrl in both silicon and the bench; the bench binds it the same way the SVA checker is bound.

Parameters:
- SDRAM_BANKS, 4, number of banks; must be a power of 2, at least 2.
- SDRAM_ROW_W, 13, address pin width.
- SDRAM_TRCD_CYCLES, 3, minimum cycles from ACTIVE to READ/WRITE on the same bank.
- SDRAM_TRP_CYCLES, 3, minimum cycles from PRECHARGE to ACTIVE on the same bank.
- SDRAM_TRAS_CYCLES, 6, minimum cycles from ACTIVE to PRECHARGE on the same bank.
- SDRAM_TRFC_CYCLES, 9, minimum cycles from REFRESH to any non-NOP command.
- SDRAM_TREFI_CYCLES, 780, maximum cycles between REFRESH commands after init.
- ERR_CNT_W, 16, error counter width.

Ports:
- clk_i  in  1  monitor clock, the same clock as sdram_ctrl.
- rst_i  in  1  asynchronous, active-low reset.
- sdram_cke_i  in  1  clock enable; commands are decoded only when this is 1.
- sdram_cs_i, sdram_ras_i, sdram_cas_i, sdram_we_i  in  1 each  command bits, cmd = {cs,ras,cas,we}.
- sdram_ba_i  in  $clog2(SDRAM_BANKS)  bank address.
- sdram_addr_i  in  SDRAM_ROW_W  address; A10 selects precharge-all.
- err_clear_i  in  1  clears err_sticky_o and err_count_o.
- init_done_o  out  1  high once the init sequence is complete.
- banks_open_o  out  SDRAM_BANKS  per-bank open flags.
- err_valid_o  out  1  one-cycle pulse for each cycle containing at least one violation.
- err_code_o  out  3  lowest-numbered violation code in that cycle.
- err_bank_o  out  $clog2(SDRAM_BANKS)  bank of the reported violation.
- err_sticky_o  out  8  per-code sticky flags.
- err_count_o  out  ERR_CNT_W  saturating count of err_valid_o pulses.
- stat_act_o, stat_rdwr_o  out  32 each  statistics counters (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; all timers 0; all banks closed; init sub-state PRE.
- Command encoding: NOP=0111, ACTIVE=0011, READ=0101, WRITE=0100, PRECHARGE=0010, REFRESH=0001, LOAD_MODE=0000. Any cmd with cs=1 is treated as NOP.
- Timers: on the triggering command each timer loads X-1 and then decrements each cycle, saturating at 0. A following command is legal iff the timer reads 0 in its cycle. Example: ACTIVE at cycle t, TRCD=3 → READ legal at t+3, violation at t+1 or t+2.
- Violation codes:
  - 0 TRCD: READ/WRITE while the bank's tRCD timer is not 0.
  - 1 TRP: ACTIVE while the bank's tRP timer is not 0.
  - 2 CLOSED: READ/WRITE to a closed bank.
  - 3 REOPEN: ACTIVE to an already-open bank.
  - 4 TRAS: PRECHARGE of an open bank while its tRAS timer is not 0. PRECHARGE-all checks every open bank; err_bank_o reports the lowest failing bank.
  - 5 REFRESH: REFRESH while any bank is open, or any non-NOP command while the tRFC timer is not 0.
  - 6 TREFI: the tREFI counter reaches SDRAM_TREFI_CYCLES. It flags once, holds saturated, and the next REFRESH restarts it.
  - 7 INIT: ACTIVE, READ or WRITE before init_done_o.
- Bank state updates are applied even when the command violates timing; the monitor keeps tracking. ACTIVE opens ba. PRECHARGE closes ba, or all banks if A10=1, and loads tRP for each closed bank. PRECHARGE of a bank that is already closed is legal.
- Init FSM: PRE (wait PRECHARGE with A10=1) → REF1 → REF2 (wait REFRESH each) → MODE (wait LOAD_MODE) → DONE.
  - Other legal commands in a sub-state are ignored; only code 7 can fire before DONE.
  - tREFI counting starts in DONE.
- Same-cycle errors: every violating code sets its sticky bit; err_code_o is the lowest of them. err_count_o increments by 1 for that cycle.
- err_clear_i has priority over a same-cycle error: the cleared state wins, and the error is not recorded.
- err_count_o saturates at all-ones.
- Reset asserted mid-operation returns the block to the reset state immediately (asynchronous).

Optional Feature:
- Macro: SDRAM_MON_STATS_EN.
- Defined: stat_act_o counts ACTIVE commands and stat_rdwr_o counts READ+WRITE commands. Both wrap at 2^32 and are cleared by err_clear_i.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package definitions gains:
  - the cmd_e enum (command encodings);
  - the mon_err_e enum (codes 0-7);
  - the init-state enum;
  - the default timing constants (SDRAM_TRCD_CYCLES etc., already shared with the controller).
- One sub-module, sdram_bank_tracker: one instance per bank via generate. It holds the open flag and the tRCD/tRAS/tRP timers, and outputs per-bank violation bits.

Test Plan:
- Reset, then PRE-all, REF, REF, MODE → init_done_o=1 at the cycle after MODE; ACTIVE issued before MODE → err_code_o=7, err_sticky_o[7]=1.
- ACTIVE bank 2, READ bank 2 after 2 cycles (TRCD=3) → err_valid_o pulse, code 0, bank 2. A repeat with READ after 3 cycles → no error.
- ACTIVE bank1, PRECHARGE bank1 after 4 cycles (TRAS=6) → code 4; ACTIVE bank1 1 cycle later → code 1. err_count_o=2.
- READ to closed bank 3 in the same cycle the tRFC timer is still running → sticky bits 2 and 5 set, err_code_o=2, err_count_o +1.
- No REFRESH for 780 cycles after init → exactly one code-6 pulse. REFRESH then restarts the count; err_clear_i in the same cycle as an error → sticky=0, count=0.
- With SDRAM_MON_STATS_EN: 5 ACTIVE and 7 READ/WRITE → stat_act_o=5, stat_rdwr_o=7. Without the macro → both stay 0.
